lsu_seq: RTL and testbench

Sequenced load/store functional unit, parametrised successor to the single-beat LSU. Accepts one decoded LDUR/STUR/LDP/STP at a time from the issue stage. Drives a handshaked single-port memory interface: one beat for single ops, two beats for pair ops. Returns results to the writeback/ROB side through a valid/ready response port. Replaces blocking waits with an explicit FSM, adds sign-extended scaled immediates, write backpressure, flush and error reporting.

---
 rtl/lsu_seq.sv | 135 +++++++++++++
 tb/tb_lsu_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_seq.sv
// lsu_seq: sequenced load/store unit for LDUR/STUR/LDP/STP.
// Accepts one op in IDLE, issues one or two memory beats, then holds the
// response until it is consumed. All outputs come from registers, so
// mem_rvalid, mem_wready and out_ready never reach an output combinationally.
module lsu_seq #(
  parameter int XLEN    = 64,
  parameter int TAG_W   = 6,
  parameter bit PAIR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst,
  input  logic [TAG_W-1:0] inst_tag,
  input  logic [XLEN-1:0]  op0,
  input  logic [XLEN-1:0]  op1,
  input  logic [XLEN-1:0]  op2,
  output logic             mem_ren,
  output logic [XLEN-1:0]  mem_raddr,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             mem_wen,
  output logic [XLEN-1:0]  mem_waddr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_wready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic [XLEN-1:0]  out0_data,
  output logic [XLEN-1:0]  out1_data,
  output logic             out_err
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  state_t state, state_nx;

  // decode of the offered word; only meaningful while in IDLE
  logic dec_ldur, dec_stur, dec_ldp, dec_stp, dec_ld, dec_st, dec_pair;
  assign dec_ldur = (inst[31:21] == 11'b11111000010);
  assign dec_stur = (inst[31:21] == 11'b11111000000);
  assign dec_ldp  = PAIR_EN && (inst[31:22] == 10'b1010100011);
  assign dec_stp  = PAIR_EN && (inst[31:22] == 10'b1010100010);
  assign dec_ld   = dec_ldur | dec_ldp;
  assign dec_st   = dec_stur | dec_stp;
  assign dec_pair = dec_ldp | dec_stp;

  // single ops use a byte offset, pair ops a doubleword-scaled one
  logic [XLEN-1:0] imm9_sx, imm7_sc, a0;
  assign imm9_sx = {{(XLEN-9){inst[20]}}, inst[20:12]};
  assign imm7_sc = {{(XLEN-10){inst[21]}}, inst[21:15], 3'b000};
  assign a0      = op0 + (dec_pair ? imm7_sc : imm9_sx);

  logic accept;
  assign accept = inst_valid && (state == IDLE);

  // captured operation context
  logic [XLEN-1:0]  addr_q, wdata_q, op2_q, d0_q, d1_q;
  logic [TAG_W-1:0] tag_q;
  logic             pair_q, ld_q, err_q;

  // next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (inst_valid) state_nx = dec_ld ? RD0 : (dec_st ? WR0 : RESP);
      RD0:  if (mem_rvalid) state_nx = pair_q ? RD1 : RESP;
      RD1:  if (mem_rvalid) state_nx = RESP;
      WR0:  if (mem_wready) state_nx = pair_q ? WR1 : RESP;
      WR1:  if (mem_wready) state_nx = RESP;
      RESP: if (out_ready)  state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // datapath: capture at accept, advance address/data per completed beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op2_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      tag_q   <= '0;
      pair_q  <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        addr_q  <= a0;
        wdata_q <= op1;
        op2_q   <= op2;
        tag_q   <= inst_tag;
        pair_q  <= dec_pair;
        ld_q    <= dec_ld;
        err_q   <= !(dec_ld || dec_st);
      end
      if (state == RD0 && mem_rvalid) begin
        d0_q   <= mem_rdata;
        addr_q <= addr_q + XLEN'(8);
      end
      if (state == RD1 && mem_rvalid) d1_q <= mem_rdata;
      if (state == WR0 && mem_wready) begin
        addr_q  <= addr_q + XLEN'(8);
        wdata_q <= op2_q;
      end
    end
  end

  assign inst_ready = (state == IDLE);
  assign mem_ren    = (state == RD0) || (state == RD1);
  assign mem_wen    = (state == WR0) || (state == WR1);
  assign mem_raddr  = addr_q;
  assign mem_waddr  = addr_q;
  assign mem_wdata  = wdata_q;
  assign out_valid  = (state == RESP);
  assign out_tag    = tag_q;
  assign out0_valid = out_valid && ld_q;
  assign out1_valid = out_valid && ld_q && pair_q;
  assign out_err    = out_valid && err_q;
  assign out0_data  = d0_q;
  assign out1_data  = d1_q;

endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: directed plus randomized checks of lsu_seq against a
// transaction-level model (decode table, address arithmetic, beat list).
module tb_lsu_seq;
  localparam int XLEN  = 64;
  localparam int TAG_W = 6;
  typedef logic [XLEN-1:0] word_t;
  typedef enum int {K_LDUR, K_STUR, K_LDP, K_STP, K_BAD} kind_t;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic inst_valid = 1'b0, inst_valid_np = 1'b0;
  logic [31:0] inst = '0;
  logic [TAG_W-1:0] inst_tag = '0;
  word_t op0 = '0, op1 = '0, op2 = '0, mem_rdata = '0;
  logic mem_rvalid = 1'b0, mem_wready = 1'b0, out_ready = 1'b0;

  logic inst_ready, mem_ren, mem_wen, out_valid, out0_valid, out1_valid, out_err;
  word_t mem_raddr, mem_waddr, mem_wdata, out0_data, out1_data;
  logic [TAG_W-1:0] out_tag;

  logic np_inst_ready, np_ren, np_wen, np_out_valid, np_out0_valid, np_out1_valid, np_err;
  word_t np_raddr, np_waddr, np_wdata, np_out0_data, np_out1_data;
  logic [TAG_W-1:0] np_out_tag;

  lsu_seq #(.XLEN(XLEN), .TAG_W(TAG_W), .PAIR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_tag(inst_tag),
    .op0(op0), .op1(op1), .op2(op2),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_data(out0_data), .out1_data(out1_data), .out_err(out_err));

  lsu_seq #(.XLEN(XLEN), .TAG_W(TAG_W), .PAIR_EN(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inst_valid(inst_valid_np), .inst_ready(np_inst_ready), .inst(inst), .inst_tag(inst_tag),
    .op0(op0), .op1(op1), .op2(op2),
    .mem_ren(np_ren), .mem_raddr(np_raddr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wen(np_wen), .mem_waddr(np_waddr), .mem_wdata(np_wdata), .mem_wready(mem_wready),
    .out_valid(np_out_valid), .out_ready(out_ready), .out_tag(np_out_tag),
    .out0_valid(np_out0_valid), .out1_valid(np_out1_valid),
    .out0_data(np_out0_data), .out1_data(np_out1_data), .out_err(np_err));

  always #5 clk = ~clk;

  int npass = 0, nfail = 0, ntot = 0;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic kind_t classify(input logic [31:0] w, input bit pair_en);
    if (w[31:21] == 11'h7C2) return K_LDUR;
    if (w[31:21] == 11'h7C0) return K_STUR;
    if (pair_en && w[31:22] == 10'h2A3) return K_LDP;
    if (pair_en && w[31:22] == 10'h2A2) return K_STP;
    return K_BAD;
  endfunction

  function automatic word_t base_addr(input kind_t k, input logic [31:0] w, input word_t b);
    longint off;
    if (k == K_LDP || k == K_STP) begin
      off = longint'(w[21:15]);
      if (off >= 64) off -= 128;
      off *= 8;
    end else begin
      off = longint'(w[20:12]);
      if (off >= 256) off -= 512;
    end
    return b + word_t'(off);
  endfunction

  function automatic logic [31:0] mk(input kind_t k, input int imm, input logic [31:0] lo);
    case (k)
      K_LDUR:  return {11'h7C2, imm[8:0], lo[11:0]};
      K_STUR:  return {11'h7C0, imm[8:0], lo[11:0]};
      K_LDP:   return {10'h2A3, imm[6:0], lo[14:0]};
      K_STP:   return {10'h2A2, imm[6:0], lo[14:0]};
      default: return {1'b0, lo[30:0]};
    endcase
  endfunction

  // one complete transaction with per-beat stall and response backpressure
  task automatic run_op(input string nm, input logic [31:0] w, input logic [TAG_W-1:0] tg,
                        input word_t b, input word_t d1, input word_t d2,
                        input int dly, input int rdly);
    kind_t k = classify(w, 1'b1);
    int beats = (k == K_LDP || k == K_STP) ? 2 : ((k == K_BAD) ? 0 : 1);
    bit is_ld = (k == K_LDUR || k == K_LDP);
    word_t a[2], wd[2], rd[2];
    a[0] = base_addr(k, w, b);
    a[1] = a[0] + 64'd8;
    wd[0] = d1; wd[1] = d2;
    chk({nm, ".rdy"}, word_t'(inst_ready), 1);
    inst_valid = 1'b1; inst = w; inst_tag = tg; op0 = b; op1 = d1; op2 = d2;
    step();
    inst_valid = 1'b0;
    inst = $urandom; inst_tag = TAG_W'($urandom);
    op0 = {$urandom, $urandom}; op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
    for (int bt = 0; bt < beats; bt++) begin
      rd[bt] = {$urandom, $urandom};
      for (int s = 0; s <= dly; s++) begin
        chk({nm, ".ren"}, word_t'(mem_ren), word_t'(is_ld));
        chk({nm, ".wen"}, word_t'(mem_wen), word_t'(!is_ld));
        if (is_ld) chk({nm, ".raddr"}, mem_raddr, a[bt]);
        else begin
          chk({nm, ".waddr"}, mem_waddr, a[bt]);
          chk({nm, ".wdata"}, mem_wdata, wd[bt]);
        end
        chk({nm, ".ovld_early"}, word_t'(out_valid), 0);
        mem_rdata = (s == dly) ? rd[bt] : {$urandom, $urandom};
        mem_rvalid = is_ld && (s == dly);
        mem_wready = !is_ld && (s == dly);
        step();
        mem_rvalid = 1'b0; mem_wready = 1'b0; mem_rdata = {$urandom, $urandom};
      end
    end
    for (int r = 0; r <= rdly; r++) begin
      chk({nm, ".ovld"}, word_t'(out_valid), 1);
      chk({nm, ".tag"}, word_t'(out_tag), word_t'(tg));
      chk({nm, ".o0v"}, word_t'(out0_valid), word_t'(is_ld));
      chk({nm, ".o1v"}, word_t'(out1_valid), word_t'(k == K_LDP));
      chk({nm, ".err"}, word_t'(out_err), word_t'(k == K_BAD));
      if (is_ld) chk({nm, ".o0d"}, out0_data, rd[0]);
      if (k == K_LDP) chk({nm, ".o1d"}, out1_data, rd[1]);
      chk({nm, ".mem_idle"}, word_t'({mem_ren, mem_wen}), 0);
      chk({nm, ".rdy_busy"}, word_t'(inst_ready), 0);
      out_ready = (r == rdly);
      step();
    end
    out_ready = 1'b0;
    chk({nm, ".done_ovld"}, word_t'(out_valid), 0);
    chk({nm, ".done_rdy"}, word_t'(inst_ready), 1);
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst.rdy", word_t'(inst_ready), 1);
    chk("rst.flags", word_t'({mem_ren, mem_wen, out_valid, out0_valid, out1_valid, out_err}), 0);
    chk("rst.raddr", mem_raddr, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.tag", word_t'(out_tag), 0);

    // directed cases
    run_op("ldur_neg", mk(K_LDUR, 'h1F8, 0), 6'h11, 64'h1000, 0, 0, 0, 0);
    run_op("ldp_stall", mk(K_LDP, 2, 32'h1234), 6'h2A, 64'h2000, 0, 0, 3, 0);
    run_op("stp_stall", mk(K_STP, 1, 0), 6'h05, 64'h3000, 64'hA, 64'hB, 4, 0);
    run_op("resp_bp", mk(K_STUR, 'h010, 0), 6'h3F, 64'h4000, 64'h77, 0, 0, 5);
    run_op("bad_zero", 32'h0, 6'h09, 64'h5000, 0, 0, 0, 0);
    run_op("wrap", mk(K_LDUR, 'h0FF, 0), 6'h01, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1, 1);

    // flush in RD1 with a same-cycle rvalid drops the op
    inst_valid = 1'b1; inst = mk(K_LDP, 0, 0); inst_tag = 6'h12; op0 = 64'h6000;
    step();
    inst_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1;
    step();
    chk("flush.rd1_ren", word_t'(mem_ren), 1);
    chk("flush.rd1_addr", mem_raddr, 64'h6008);
    flush = 1'b1; mem_rdata = 64'h2;
    step();
    flush = 1'b0; mem_rvalid = 1'b0;
    chk("flush.ovld", word_t'(out_valid), 0);
    chk("flush.rdy", word_t'(inst_ready), 1);
    chk("flush.ren", word_t'(mem_ren), 0);
    step();
    chk("flush.ovld2", word_t'(out_valid), 0);
    run_op("post_flush", mk(K_LDUR, 8, 0), 6'h13, 64'h7000, 0, 0, 0, 0);

    // pair ops on a pair-less build report an error at T+1 without memory access
    inst_valid_np = 1'b1; inst = mk(K_LDP, 2, 0); inst_tag = 6'h21; op0 = 64'h8000;
    step();
    inst_valid_np = 1'b0;
    chk("np.ovld", word_t'(np_out_valid), 1);
    chk("np.err", word_t'(np_err), 1);
    chk("np.tag", word_t'(np_out_tag), 6'h21);
    chk("np.mem", word_t'({np_ren, np_wen}), 0);
    chk("np.o0v", word_t'(np_out0_valid), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("np.rdy", word_t'(np_inst_ready), 1);

    // reset in the middle of a store clears everything
    inst_valid = 1'b1; inst = mk(K_STUR, 4, 0); inst_tag = 6'h2C;
    op0 = 64'h9000; op1 = 64'hCAFE;
    step();
    inst_valid = 1'b0;
    chk("rstmid.wen", word_t'(mem_wen), 1);
    chk("rstmid.waddr", mem_waddr, 64'h9004);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstmid.rdy", word_t'(inst_ready), 1);
    chk("rstmid.wen0", word_t'(mem_wen), 0);
    chk("rstmid.addr", mem_waddr, 0);
    chk("rstmid.wdata", mem_wdata, 0);
    chk("rstmid.tag", word_t'(out_tag), 0);
    chk("rstmid.data", out0_data | out1_data, 0);
    chk("rstmid.ovld", word_t'(out_valid), 0);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      kind_t k = kind_t'($urandom_range(0, 4));
      run_op("rand", mk(k, int'($urandom), $urandom), TAG_W'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
